// File: rtl/transaction_state_ctrl.sv
// Transaction state controller: sequences RESET/INIT/IDLE/ACTIVE/ERROR from FIFO
// empty/error flags and holds the D0/D1 FIFO thresholds loaded during INIT.
module transaction_state_ctrl #(
    parameter int UMBRAL_WIDTH = 4,
    parameter int IDLE_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [UMBRAL_WIDTH-1:0] Umbral_D0_in,
    input  logic [UMBRAL_WIDTH-1:0] Umbral_D1_in,
    input  logic                    empty_fifo_VC0,
    input  logic                    empty_fifo_VC1,
    input  logic                    empty_fifo_D0,
    input  logic                    empty_fifo_D1,
    input  logic                    error_D0,
    input  logic                    error_D1,
    output logic [UMBRAL_WIDTH-1:0] Umbral_D0,
    output logic [UMBRAL_WIDTH-1:0] Umbral_D1,
    output logic [2:0]              state,
    output logic                    active_out,
    output logic                    idle_out,
    output logic                    error_out,
    output logic [1:0]              error_src
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [3:0] IDLE_LIMIT = 4'(IDLE_CYCLES);

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] empty_cnt;
    logic [3:0] cnt_nxt;
    logic       all_empty;
    logic       any_error;

    assign all_empty = empty_fifo_VC0 & empty_fifo_VC1 & empty_fifo_D0 & empty_fifo_D1;
    assign any_error = error_D0 | error_D1;
    assign state     = cur_state;

    // Saturating run length of all-empty edges seen while ACTIVE.
    always_comb begin
        cnt_nxt = '0;
        if (cur_state == ST_ACTIVE && all_empty)
            cnt_nxt = (empty_cnt == 4'hF) ? empty_cnt : empty_cnt + 4'd1;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_RESET:  nxt_state = ST_INIT;
            ST_INIT: begin
                if (any_error)      nxt_state = ST_ERROR;
                else if (init)      nxt_state = ST_INIT;
                else if (all_empty) nxt_state = ST_IDLE;
                else                nxt_state = ST_ACTIVE;
            end
            ST_IDLE: begin
                if (any_error)       nxt_state = ST_ERROR;
                else if (init)       nxt_state = ST_INIT;
                else if (!all_empty) nxt_state = ST_ACTIVE;
                else                 nxt_state = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (any_error)                             nxt_state = ST_ERROR;
                else if (init)                             nxt_state = ST_INIT;
                else if (all_empty && cnt_nxt >= IDLE_LIMIT) nxt_state = ST_IDLE;
                else                                       nxt_state = ST_ACTIVE;
            end
            ST_ERROR:  nxt_state = ST_ERROR;
            default:   nxt_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cur_state  <= ST_RESET;
            empty_cnt  <= '0;
            Umbral_D0  <= '0;
            Umbral_D1  <= '0;
            error_src  <= '0;
            active_out <= 1'b0;
            idle_out   <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            empty_cnt <= cnt_nxt;
            if (cur_state == ST_INIT) begin
                Umbral_D0 <= Umbral_D0_in;
                Umbral_D1 <= Umbral_D1_in;
            end
            // Capture the error source only on the entering edge; ERROR holds it.
            if (nxt_state == ST_ERROR)
                error_src <= (cur_state == ST_ERROR) ? error_src : {error_D1, error_D0};
            else
                error_src <= '0;
            active_out <= (nxt_state == ST_ACTIVE);
            idle_out   <= (nxt_state == ST_IDLE);
            error_out  <= (nxt_state == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_transaction_state_ctrl.sv
// Self-checking bench for transaction_state_ctrl: directed scenarios followed by
// randomized traffic, both scored against a behavioural model of the state rules.
module tb_transaction_state_ctrl;

    localparam int UW   = 4;
    localparam int IDLE = 2;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          init;
    logic [UW-1:0] u0_in, u1_in;
    logic [3:0]    emp;  // {VC0, VC1, D0, D1}
    logic          e0, e1;
    logic [UW-1:0] u0, u1;
    logic [2:0]    st;
    logic          act, idl, err;
    logic [1:0]    src;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_state;
    int            m_run;
    logic [UW-1:0] m_u0, m_u1;
    logic [1:0]    m_src;

    transaction_state_ctrl #(.UMBRAL_WIDTH(UW), .IDLE_CYCLES(IDLE)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .Umbral_D0_in(u0_in), .Umbral_D1_in(u1_in),
        .empty_fifo_VC0(emp[3]), .empty_fifo_VC1(emp[2]),
        .empty_fifo_D0(emp[1]), .empty_fifo_D1(emp[0]),
        .error_D0(e0), .error_D1(e1),
        .Umbral_D0(u0), .Umbral_D1(u1), .state(st),
        .active_out(act), .idle_out(idl), .error_out(err), .error_src(src)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [2:0] flags;
        flags = {m_state == 3, m_state == 2, m_state == 4};
        check_val("state", 32'(st), 32'(m_state));
        check_val("umbral_d0", 32'(u0), 32'(m_u0));
        check_val("umbral_d1", 32'(u1), 32'(m_u1));
        check_val("error_src", 32'(src), 32'(m_src));
        check_val("flags", 32'({act, idl, err}), 32'(flags));
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_u0 = '0; m_u1 = '0; m_src = '0;
    endtask

    // Next-state rules evaluated from the values presented for the coming edge.
    task automatic model_step();
        int  ns;
        bit  all_e, any_e;
        all_e = (emp == 4'hF);
        any_e = e0 | e1;
        if (m_state == 3 && all_e) m_run = (m_run < 15) ? m_run + 1 : 15;
        else                       m_run = 0;
        case (m_state)
            0: ns = 1;
            1: ns = any_e ? 4 : init ? 1 : all_e ? 2 : 3;
            2: ns = any_e ? 4 : init ? 1 : !all_e ? 3 : 2;
            3: ns = any_e ? 4 : init ? 1 : (all_e && m_run >= IDLE) ? 2 : 3;
            default: ns = 4;
        endcase
        if (m_state == 1) begin
            m_u0 = u0_in;
            m_u1 = u1_in;
        end
        if (ns != 4)           m_src = 2'b00;
        else if (m_state != 4) m_src = {e1, e0};
        m_state = ns;
    endtask

    // Apply inputs (called at negedge), clock one edge, check at the next negedge.
    task automatic cycle(input logic i, input logic [3:0] em, input logic er0, input logic er1,
                         input logic [UW-1:0] a, input logic [UW-1:0] b);
        init = i; emp = em; e0 = er0; e1 = er1; u0_in = a; u1_in = b;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    // Asserted between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        #2 reset_L = 1'b0;
        #1;
        check_val("async_rst_state", 32'(st), 32'd0);
        check_val("async_rst_outs", 32'({u0, u1, src, act, idl, err}), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_model();
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0; emp = 4'hF; e0 = 1'b0; e1 = 1'b0;
        u0_in = '0; u1_in = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_model();
        reset_L = 1'b1;

        // Load thresholds through INIT, then settle into IDLE.
        cycle(1, 4'hF, 0, 0, 4'd5, 4'd9);
        check_val("first_init", 32'(st), 32'd1);
        cycle(1, 4'hF, 0, 0, 4'd5, 4'd9);
        check_val("umbral_loaded", 32'({u0, u1}), 32'h59);
        cycle(1, 4'hF, 0, 0, 4'd5, 4'd9);
        cycle(0, 4'hF, 0, 0, 4'd5, 4'd9);
        check_val("idle_reached", 32'({st, idl}), 32'({3'd2, 1'b1}));

        // IDLE -> ACTIVE -> IDLE after exactly two empty edges.
        cycle(0, 4'b0111, 0, 0, 4'd5, 4'd9);
        check_val("active_reached", 32'({st, act}), 32'({3'd3, 1'b1}));
        cycle(0, 4'hF, 0, 0, 4'd5, 4'd9);
        check_val("still_active", 32'(st), 32'd3);
        cycle(0, 4'hF, 0, 0, 4'd5, 4'd9);
        check_val("idle_after_2", 32'(st), 32'd2);

        // A one-cycle non-empty glitch restarts the count.
        cycle(0, 4'b1101, 0, 0, 4'd5, 4'd9);
        cycle(0, 4'hF, 0, 0, 4'd5, 4'd9);
        cycle(0, 4'b1110, 0, 0, 4'd5, 4'd9);
        cycle(0, 4'hF, 0, 0, 4'd5, 4'd9);
        check_val("glitch_restart", 32'(st), 32'd3);
        cycle(0, 4'hF, 0, 0, 4'd5, 4'd9);
        check_val("glitch_idle", 32'(st), 32'd2);

        // Threshold change outside INIT is ignored until INIT is re-entered.
        cycle(0, 4'b1011, 0, 0, 4'd3, 4'd9);
        check_val("umbral_hold", 32'(u0), 32'd5);
        cycle(1, 4'b1011, 0, 0, 4'd3, 4'd9);
        check_val("reinit_state", 32'({st, u0}), 32'({3'd1, 4'd5}));
        cycle(0, 4'b1011, 0, 0, 4'd3, 4'd9);
        check_val("umbral_reload", 32'({st, u0}), 32'({3'd3, 4'd3}));

        // Error in ACTIVE is sticky and records its source.
        cycle(0, 4'b1011, 0, 1, 4'd3, 4'd9);
        check_val("error_entry", 32'({st, err, src}), 32'({3'd4, 1'b1, 2'b10}));
        cycle(1, 4'hF, 0, 0, 4'd7, 4'd7);
        cycle(0, 4'hF, 1, 0, 4'd7, 4'd7);
        check_val("error_sticky", 32'({st, src, u0}), 32'({3'd4, 2'b10, 4'd3}));

        async_reset();
        cycle(1, 4'hF, 0, 0, 4'd2, 4'd4);
        check_val("post_rst_init", 32'(st), 32'd1);
        cycle(0, 4'hF, 0, 0, 4'd2, 4'd4);
        // Error outranks init in IDLE.
        cycle(1, 4'hF, 1, 0, 4'd2, 4'd4);
        check_val("err_over_init", 32'({st, src}), 32'({3'd4, 2'b01}));
        async_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic          ri, re0, re1;
            logic [3:0]    rem;
            logic [UW-1:0] ra, rb;
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                ri  = ($urandom_range(0, 9) == 0);
                re0 = ($urandom_range(0, 79) == 0);
                re1 = ($urandom_range(0, 79) == 0);
                rem = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
                ra  = UW'($urandom);
                rb  = UW'($urandom);
                cycle(ri, rem, re0, re1, ra, rb);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
